// File: rtl/gray_conv_arbiter.sv
// ---------------------------------------------------------------------------
// gray_conv_arbiter
//
// Round-robin arbiter that shares one registered binary-to-Gray conversion
// stage among NREQ requesters. One requester is granted at a time. Its word is
// captured, converted on the following edge, and presented on the response
// channel until the consumer accepts it.
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   req_valid   per-requester request valid                  [NREQ]
//   req_bin     per-requester binary word, slice i*WIDTH     [NREQ*WIDTH]
//   req_ready   per-requester accept, one-hot or zero        [NREQ]
//   resp_valid  response valid (registered)
//   resp_ready  response consumer ready
//   resp_gray   Gray code of the accepted word               [WIDTH]
//   resp_bin    accepted binary word, echoed                 [WIDTH]
//   resp_id     index of the requester owning the response   [IDW]
//   busy        high whenever the FSM is not idle (registered)
//   conv_count  completed response handshakes, wraps 255->0  [8]
// ---------------------------------------------------------------------------
module gray_conv_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_bin,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH-1:0]        resp_gray,
    output logic [WIDTH-1:0]        resp_bin,
    output logic [IDW-1:0]          resp_id,
    output logic                    busy,
    output logic [7:0]              conv_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDW-1:0]     last_grant_reg;
    logic [WIDTH-1:0]   bin_reg;
    logic [IDW-1:0]     id_reg;
    logic               resp_valid_reg;
    logic [WIDTH-1:0]   resp_gray_reg;
    logic [WIDTH-1:0]   resp_bin_reg;
    logic [IDW-1:0]     resp_id_reg;
    logic               busy_reg;
    logic [7:0]         conv_count_reg;

    // Per-requester views of the packed request bus.
    logic [WIDTH-1:0]   req_word [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign req_word[gi] = req_bin[gi*WIDTH +: WIDTH];
    end

    // Round-robin candidate order: candidate k is (last_grant + 1 + k) mod NREQ.
    // The sum never exceeds 2*NREQ-1, so one conditional subtraction is enough
    // to wrap it, and IDW+1 bits always hold it.
    logic [IDW-1:0]     cand_idx [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IDW:0] cand_sum;
        assign cand_sum     = {1'b0, last_grant_reg} + (IDW+1)'(gi + 1);
        assign cand_idx[gi] = (cand_sum >= (IDW+1)'(NREQ))
                            ? IDW'(cand_sum - (IDW+1)'(NREQ))
                            : cand_sum[IDW-1:0];
    end

    // Pick the first valid candidate. Scanning from the far end downward lets
    // the nearest candidate overwrite any later one.
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[cand_idx[i]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    // A request is accepted only in IDLE and never while reset is held.
    logic               accept;
    assign accept = (state_reg == IDLE) && grant_found && !rst;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
    end

    // Gray conversion of the captured word: the MSB passes through, and each
    // lower bit is the XOR of itself with its upper neighbour.
    logic [WIDTH-1:0]   gray_next;

    assign gray_next[WIDTH-1] = bin_reg[WIDTH-1];
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
        assign gray_next[gi] = bin_reg[gi+1] ^ bin_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDW'(NREQ - 1);
            bin_reg        <= '0;
            id_reg         <= '0;
            resp_valid_reg <= 1'b0;
            resp_gray_reg  <= '0;
            resp_bin_reg   <= '0;
            resp_id_reg    <= '0;
            busy_reg       <= 1'b0;
            conv_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bin_reg        <= req_word[grant_idx];
                        id_reg         <= grant_idx;
                        last_grant_reg <= grant_idx;
                        busy_reg       <= 1'b1;
                        state_reg      <= CONVERT;
                    end
                end
                CONVERT: begin
                    resp_gray_reg  <= gray_next;
                    resp_bin_reg   <= bin_reg;
                    resp_id_reg    <= id_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= HOLD;
                end
                HOLD: begin
                    // Response data stays frozen until the consumer takes it.
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        conv_count_reg <= conv_count_reg + 8'd1;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_gray  = resp_gray_reg;
    assign resp_bin   = resp_bin_reg;
    assign resp_id    = resp_id_reg;
    assign busy       = busy_reg;
    assign conv_count = conv_count_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model records when each request is accepted and derives the
// expected response timing, data and grant order from that.
// ---------------------------------------------------------------------------
module tb_gray_conv_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WIDTH-1:0]  req_bin;
    logic [NREQ-1:0]        req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WIDTH-1:0]       resp_gray;
    logic [WIDTH-1:0]       resp_bin;
    logic [IDW-1:0]         resp_id;
    logic                   busy;
    logic [7:0]             conv_count;

    gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_bin    (req_bin),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_gray  (resp_gray),
        .resp_bin   (resp_bin),
        .resp_id    (resp_id),
        .busy       (busy),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one outstanding job, remembered by the edge it was
    // accepted on. The response becomes visible two edges after the accept.
    bit m_pending;
    int m_acc;
    int m_last;
    int m_count;
    int m_bin_cap, m_id_cap;
    int m_show_gray, m_show_bin, m_show_id;
    int cyc = 0;
    int dut_grants[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending   = 1'b0;
        m_acc       = -10;
        m_last      = NREQ - 1;
        m_count     = 0;
        m_show_gray = 0;
        m_show_bin  = 0;
        m_show_id   = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check req_ready,
    // advance the model across the rising edge, then check registered outputs.
    task automatic run_cycle(input logic r, input logic [NREQ-1:0] v,
                             input logic [NREQ*WIDTH-1:0] b, input logic rr);
        int g;
        logic [NREQ-1:0] exp_ready;
        bit exp_valid;
        rst        = r;
        req_valid  = v;
        req_bin    = b;
        resp_ready = rr;
        #1;
        g = -1;
        if (!r && !m_pending) begin
            for (int off = 1; off <= NREQ; off++) begin
                int i;
                i = (m_last + off) % NREQ;
                if (g < 0 && v[i]) g = i;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        if (req_ready != '0) begin
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) dut_grants.push_back(i);
        end

        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (g >= 0) begin
            m_pending = 1'b1;
            m_acc     = cyc;
            m_bin_cap = int'(b >> (g * WIDTH)) & MASK;
            m_id_cap  = g;
            m_last    = g;
        end else if (m_pending && cyc == m_acc + 1) begin
            m_show_bin  = m_bin_cap;
            m_show_gray = (m_bin_cap ^ (m_bin_cap >> 1)) & MASK;
            m_show_id   = m_id_cap;
        end else if (m_pending && cyc >= m_acc + 2 && rr) begin
            m_pending = 1'b0;
            m_count   = (m_count + 1) % 256;
            $display("resp id=%0d bin=%h gray=%h count=%0d",
                     m_show_id, m_show_bin[WIDTH-1:0], m_show_gray[WIDTH-1:0], m_count);
        end
        cyc++;

        @(negedge clk);
        exp_valid = m_pending && (cyc >= m_acc + 2);
        check_eq("resp_valid", 32'(resp_valid), 32'(exp_valid));
        check_eq("busy",       32'(busy),       32'(m_pending));
        check_eq("conv_count", 32'(conv_count), 32'(m_count));
        check_eq("resp_gray",  32'(resp_gray),  32'(m_show_gray));
        check_eq("resp_bin",   32'(resp_bin),   32'(m_show_bin));
        check_eq("resp_id",    32'(resp_id),    32'(m_show_id));
    endtask

    function automatic logic [NREQ*WIDTH-1:0] put_word(input int idx, input int val);
        logic [NREQ*WIDTH-1:0] w;
        w = '0;
        w[idx*WIDTH +: WIDTH] = WIDTH'(val);
        return w;
    endfunction

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_bin    = '0;
        resp_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        run_cycle(1'b1, 4'b1111, '1, 1'b1);
        run_cycle(1'b1, 4'b0000, '0, 1'b0);

        // Single request: requester 0 sends 1010
        dut_grants.delete();
        run_cycle(1'b0, 4'b0001, put_word(0, 4'b1010), 1'b1);
        run_cycle(1'b0, 4'b0000, '0, 1'b1);
        run_cycle(1'b0, 4'b0000, '0, 1'b1);
        run_cycle(1'b0, 4'b0000, '0, 1'b1);
        check_eq("single_grant_n", 32'(dut_grants.size()), 32'd1);
        if (dut_grants.size() >= 1) check_eq("single_grant", 32'(dut_grants[0]), 32'd0);
        check_eq("single_gray", 32'(resp_gray), 32'b1111);
        check_eq("single_bin",  32'(resp_bin),  32'b1010);
        check_eq("single_id",   32'(resp_id),   32'd0);

        // Exhaustive conversion through requester 2
        run_cycle(1'b1, 4'b0000, '0, 1'b0);
        for (int val = 0; val < 16; val++) begin
            run_cycle(1'b0, 4'b0100, put_word(2, val), 1'b1);
            run_cycle(1'b0, 4'b0000, '0, 1'b1);
            run_cycle(1'b0, 4'b0000, '0, 1'b1);
            check_eq("exh_gray", 32'(resp_gray), 32'((val ^ (val >> 1)) & MASK));
            if (val == 15) check_eq("exh_gray_f", 32'(resp_gray), 32'b1000);
            if (val == 6)  check_eq("exh_gray_6", 32'(resp_gray), 32'b0101);
        end
        check_eq("exh_count16", 32'(conv_count), 32'd16);

        // Fairness: all requesters valid continuously
        run_cycle(1'b1, 4'b0000, '0, 1'b0);
        dut_grants.delete();
        for (int k = 0; k < 24; k++)
            run_cycle(1'b0, 4'b1111, 16'h4321, 1'b1);
        check_eq("fair_n", 32'(dut_grants.size()), 32'd8);
        for (int k = 0; k < dut_grants.size(); k++)
            check_eq("fair_order", 32'(dut_grants[k]), 32'(k % NREQ));

        // Backpressure: requester 1 sends 1100, consumer stalls 5 cycles
        run_cycle(1'b0, 4'b0010, put_word(1, 4'b1100), 1'b0);
        run_cycle(1'b0, 4'b0000, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run_cycle(1'b0, 4'b1111, '1, 1'b0);
            check_eq("bp_gray", 32'(resp_gray), 32'b1010);
        end
        run_cycle(1'b0, 4'b0000, '0, 1'b1);
        check_eq("bp_idle", 32'(busy), 32'd0);

        // Reset while a response from requester 3 is pending
        run_cycle(1'b1, 4'b0000, '0, 1'b0);
        run_cycle(1'b0, 4'b1000, put_word(3, 4'b0111), 1'b0);
        run_cycle(1'b0, 4'b1000, '0, 1'b0);
        run_cycle(1'b0, 4'b1000, '0, 1'b0);
        run_cycle(1'b1, 4'b1001, '0, 1'b0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),       32'd0);
        check_eq("rst_count", 32'(conv_count), 32'd0);
        dut_grants.delete();
        run_cycle(1'b0, 4'b1001, '0, 1'b1);
        check_eq("rst_grant_n", 32'(dut_grants.size()), 32'd1);
        if (dut_grants.size() >= 1) check_eq("rst_grant0", 32'(dut_grants[0]), 32'd0);

        // Random traffic without reset: long enough for the counter to wrap
        for (int k = 0; k < 1500; k++)
            run_cycle(1'b0, NREQ'($urandom_range(0, (1 << NREQ) - 1)),
                      (NREQ*WIDTH)'($urandom), ($urandom_range(0, 3) != 0));

        // Random traffic with occasional resets
        for (int k = 0; k < 1000; k++)
            run_cycle(($urandom_range(0, 199) == 0), NREQ'($urandom_range(0, (1 << NREQ) - 1)),
                      (NREQ*WIDTH)'($urandom), ($urandom_range(0, 2) != 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
